// File: rtl/branch_flag_unit.sv
// Execute-stage flag register and conditional branch resolver.
// Captures ALU S/Z/C/V flags, forwards them to branches in the same cycle, and drives taken/target/flush.
module branch_flag_unit #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [3:0]      alu_op,
    input  logic [3:0]      alu_szcv,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [7:0]      br_disp,
    output logic [3:0]      flags,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic            flush
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state, next_state;
    logic [2:0]      cnt, next_cnt;
    logic [3:0]      eff_flags;
    logic            cond_met;
    logic            take;
    logic [PC_W-1:0] br_target;
    logic            unused_alu_c;

    // The ALU carry is never architecturally kept; C is always forced to 0.
    assign unused_alu_c = alu_szcv[1];

    assign flush    = (state == FLUSH);
    assign br_ready = !flush;

    always_comb begin
        eff_flags = flags;
        if (alu_valid && !flush) begin
            case (alu_op)
                4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111: eff_flags = flags;
                default: eff_flags = {alu_szcv[3], alu_szcv[2], 1'b0,
                                      ((alu_op == 4'b0000) || (alu_op == 4'b0001) ||
                                       (alu_op == 4'b0101)) ? alu_szcv[0] : 1'b0};
            endcase
        end
    end

    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            3'b000:  cond_met = eff_flags[2];
            3'b001:  cond_met = eff_flags[3] ^ eff_flags[0];
            3'b010:  cond_met = eff_flags[2] | (eff_flags[3] ^ eff_flags[0]);
            3'b011:  cond_met = !eff_flags[2];
            3'b100:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign take      = br_valid && br_ready && cond_met;
    assign br_target = br_pc + PC_W'(1) + {{(PC_W-8){br_disp[7]}}, br_disp};

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    next_state = FLUSH;
                    next_cnt   = 3'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (cnt <= 3'd1) begin
                    next_state = IDLE;
                    next_cnt   = 3'd0;
                end else begin
                    next_cnt = cnt - 3'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            flags  <= 4'b0000;
            taken  <= 1'b0;
            target <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            flags <= eff_flags;
            taken <= take;
            if (take) begin
                target <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: stimulus pushes reference-model predictions,
// a monitor pops and compares them one cycle later.
module tb_branch_flag_unit;

    localparam int PC_W         = 16;
    localparam int FLUSH_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_op;
    logic [3:0]  alu_szcv;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [7:0]  br_disp;
    logic [3:0]  flags;
    logic        taken;
    logic [15:0] target;
    logic        flush;

    typedef struct {
        logic        taken;
        logic [15:0] target;
        logic        flush;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_flags;
    logic [15:0] m_target;
    int          m_flush_left;

    branch_flag_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_op(alu_op),
        .alu_szcv(alu_szcv), .br_valid(br_valid), .br_ready(br_ready),
        .br_cond(br_cond), .br_pc(br_pc), .br_disp(br_disp), .flags(flags),
        .taken(taken), .target(target), .flush(flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and predicts the outputs visible after the next rising edge.
    task automatic applyStimulus(input logic av, input logic [3:0] op, input logic [3:0] szcv,
                                 input logic bv, input logic [2:0] cond,
                                 input logic [15:0] pc, input logic [7:0] disp);
        logic       flushing;
        logic [3:0] nf;
        logic       s, z, v, hit, tk;
        int         sum;
        exp_t       e;
        @(negedge clk);
        alu_valid = av; alu_op = op; alu_szcv = szcv;
        br_valid = bv; br_cond = cond; br_pc = pc; br_disp = disp;

        flushing = (m_flush_left > 0);
        nf = m_flags;
        if (av && !flushing && !(op == 4'd7 || op >= 4'd12))
            nf = {szcv[3], szcv[2], 1'b0, (op == 4'd0 || op == 4'd1 || op == 4'd5) ? szcv[0] : 1'b0};
        s = nf[3]; z = nf[2]; v = nf[0];
        case (cond)
            3'd0:    hit = z;
            3'd1:    hit = (s != v);
            3'd2:    hit = z || (s != v);
            3'd3:    hit = !z;
            3'd4:    hit = 1'b1;
            default: hit = 1'b0;
        endcase
        tk = bv && !flushing && hit;
        if (flushing) m_flush_left--;
        if (tk) begin
            sum = int'(pc) + 1 + int'($signed(disp));
            m_target = 16'(sum & 32'h0000_FFFF);
            m_flush_left = FLUSH_CYCLES;
        end
        m_flags = nf;
        e.taken = tk; e.target = m_target; e.flush = (m_flush_left > 0); e.flags = m_flags;
        exp_q.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0, 8'd0);
    endtask

    task automatic resetModel();
        m_flags = 4'b0000; m_target = 16'h0000; m_flush_left = 0;
    endtask

    // Monitor: every cycle the DUT presents a fresh output set one delta past the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("taken",    int'(taken),    int'(e.taken));
                checkOutput("target",   int'(target),   int'(e.target));
                checkOutput("flush",    int'(flush),    int'(e.flush));
                checkOutput("br_ready", int'(br_ready), int'(!e.flush));
                checkOutput("flags",    int'(flags),    int'(e.flags));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_op = 4'd0; alu_szcv = 4'd0;
        br_valid = 1'b0; br_cond = 3'd0; br_pc = 16'd0; br_disp = 8'd0;
        resetModel();
        #3;
        checkOutput("reset_flags",    int'(flags),    0);
        checkOutput("reset_taken",    int'(taken),    0);
        checkOutput("reset_flush",    int'(flush),    0);
        checkOutput("reset_target",   int'(target),   0);
        checkOutput("reset_br_ready", int'(br_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle CMP result forwarded into BE
        applyStimulus(1'b1, 4'b0101, 4'b0100, 1'b1, 3'b000, 16'h0010, 8'h05);
        repeat (3) idleCycle();

        // Signed compare: S=1,V=0 then S=1,V=1
        applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0, 3'd0, 16'd0, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b001, 16'h0100, 8'hF0);
        repeat (3) idleCycle();
        applyStimulus(1'b1, 4'b0000, 4'b1001, 1'b0, 3'd0, 16'd0, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b001, 16'h0200, 8'h10);

        // V masked for logical ops, then BLE, then squashed inputs during flush
        applyStimulus(1'b1, 4'b0010, 4'b1001, 1'b0, 3'd0, 16'd0, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b010, 16'h0300, 8'h02);
        applyStimulus(1'b1, 4'b0000, 4'b0100, 1'b1, 3'b100, 16'h0400, 8'h01);
        applyStimulus(1'b1, 4'b0000, 4'b0100, 1'b1, 3'b100, 16'h0500, 8'h01);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b100, 16'h0600, 8'h03);
        repeat (3) idleCycle();

        // Wrap-around and reserved condition
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b100, 16'hFFFF, 8'h00);
        repeat (3) idleCycle();
        applyStimulus(1'b1, 4'b0001, 4'b0100, 1'b1, 3'b110, 16'h1234, 8'h7F);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b011, 16'h2000, 8'h80);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b011, 16'h2001, 8'h80);

        // Asynchronous reset while flush is high
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 3'b100, 16'h4000, 8'h10);
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b0; br_valid = 1'b0;
        #1;
        checkOutput("midreset_flags", int'(flags), 0);
        checkOutput("midreset_flush", int'(flush), 0);
        checkOutput("midreset_taken", int'(taken), 0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                          16'($urandom), 8'($urandom));
        end
        repeat (3) idleCycle();
        @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Sits downstream of the ALU/shifter in the execute stage.
- Captures the 4-bit S/Z/C/V flag result into an architectural flag register and evaluates conditional branches against it.
- Produces a registered taken/target pulse plus a multi-cycle pipeline flush.
- Flag producer is the ALU; this block is its consumer and the branch resolver for the PC/fetch logic.

Parameters:
PC_W, 16, width of program counter and branch target
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal 1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result this cycle is architecturally valid
alu_op  in  4  ALU opcode of that result (0000 ADD … 1011 SRA)
alu_szcv  in  4  ALU flags {S,Z,C,V}
br_valid  in  1  branch request present
br_ready  out  1  block can accept a branch this cycle
br_cond  in  3  000 BE, 001 BLT, 010 BLE, 011 BNE, 100 B (always), 101-111 reserved
br_pc  in  PC_W  PC of the branch instruction
br_disp  in  8  signed displacement
flags  out  4  current flag register {S,Z,C,V}
taken  out  1  one-cycle pulse: accepted branch resolved taken
target  out  PC_W  branch target, valid when taken=1
flush  out  1  squash younger instructions

Behaviour:
- Reset (async, rst_n=0): flags=0000, taken=0, target=0, flush=0, flush counter=0, br_ready=1 after release.
- Flag capture on posedge when alu_valid=1 and flush=0:
  - ops 0000-0110, 1000-1011: S,Z from alu_szcv; C forced 0.
  - V = alu_szcv[0] only for ops 0000/0001/0101; otherwise 0 (ALU V is X there; never let X into the register).
  - ops 0111, 11xx: flags unchanged.
- Forwarding: branch evaluation uses "effective flags" = the value that would be captured this cycle if a capture occurs, else the current register. An ALU result and a branch in the same cycle resolve against the new flags.
- Conditions, with eff flags S,Z,V:
  - BE: Z
  - BLT: S^V
  - BLE: Z | (S^V)
  - BNE: !Z
  - B: 1
  - reserved: 0 (not taken, no flush)
- Handshake: br_ready = !flush. Branch accepted when br_valid & br_ready. br_valid while br_ready=0 is dropped; the producer squashes it, no retention.
- Latency: accept at edge N → taken/target registered, visible after edge N. taken is high exactly one cycle. Not-taken: taken=0, target holds its previous value.
- target = br_pc + 1 + sign_extend(br_disp), truncated mod 2^PC_W (wrap-around required, e.g. FFFF+1+0 = 0000).
- Flush FSM, states IDLE / FLUSH:
  - IDLE→FLUSH on a taken accept; counter loads FLUSH_CYCLES.
  - flush=1 from the taken cycle for exactly FLUSH_CYCLES cycles; counter decrements each cycle; →IDLE when it reaches 0.
  - In FLUSH: alu_valid is ignored (no flag update), branches are not accepted.
- Back-to-back not-taken branches are accepted every cycle.
- Reset mid-flush: immediately IDLE, flush=0, flags=0000.

Test Plan:
- Reset: rst_n low mid-run with flush=1 → flags=0000, flush=0, taken=0 asynchronously, before the next edge.
- Forwarding: alu_valid, op=0101 CMP, szcv=0100, same cycle br_cond=000 BE, pc=0010, disp=05 → next cycle taken=1, target=0016, flush high 2 cycles, br_ready low 2 cycles.
- Signed compare: flags S=1,V=0; BLT, pc=0100, disp=F0 (-16) → taken, target=00F1. With S=1,V=1: BLT not taken, taken=0, no flush.
- V masking: op=0010 AND with szcv=1001 → flags=1000. Then BLE → taken.
- Flush squash: during flush apply alu_valid op=0000 szcv=0100 and br_valid B → flags unchanged, no second taken pulse. After flush ends, a B is accepted next cycle.
- Wrap/reserved: pc=FFFF, disp=00, B → target=0000. br_cond=110 → taken=0, flush=0, br_ready stays 1.
